// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seq_detect_ctrl                                            |
// | Description : Run sequencer for the sequence detector datapath. Streams a|
// |               latched N-bit pattern MSB-first into the detector after a  |
// |               one-cycle detector reset, counts Z hits with Mealy/Moore   |
// |               sampling and pulses done. Optional first-hit capture is    |
// |               enabled with macro SEQ_CTRL_FIRST_HIT_EN.                  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module seq_detect_ctrl #(
    parameter int N  = 44,
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic [N-1:0]  pattern,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] hit_count,
    output logic          det_reset,
    output logic          det_x,
    output logic          det_m,
`ifdef SEQ_CTRL_FIRST_HIT_EN
    output logic [CW-1:0] first_hit,
    output logic          first_valid,
`endif
    input  logic          det_z
);

    // Bit index only has to reach N-1, independent of the counter width.
    localparam int            IW         = (N > 2) ? $clog2(N) : 1;
    localparam logic [IW-1:0] c_last_idx = IW'(N - 1);
    localparam logic [CW-1:0] c_cnt_max  = {CW{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RST   = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        r_state;
    logic [N-1:0]  r_shift;
    logic [IW-1:0] r_idx;
    logic          r_done;
    logic [CW-1:0] r_hit_count;
    logic          r_det_reset;
    logic          r_det_x;
    logic          r_det_m;
    logic          w_sample;
    logic          w_hit;

    // Mealy samples Z alongside each bit; Moore one cycle later, so the
    // last bit's Moore sample lands in DRAIN and RUN cycle 0 is skipped.
    always_comb begin
        w_sample = 1'b0;
        if (r_state == S_RUN) begin
            w_sample = !r_det_m || (r_idx != '0);
        end else if (r_state == S_DRAIN) begin
            w_sample = r_det_m;
        end
    end

    assign w_hit = w_sample & det_z;

`ifdef SEQ_CTRL_FIRST_HIT_EN
    logic [IW-1:0] w_sample_idx;
    logic [CW-1:0] r_first_hit;
    logic          r_first_valid;

    always_comb begin
        w_sample_idx = r_idx;
        if (r_state == S_DRAIN) begin
            w_sample_idx = c_last_idx;
        end else if (r_det_m) begin
            w_sample_idx = r_idx - IW'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_idx       <= '0;
            r_done      <= 1'b0;
            r_hit_count <= '0;
            r_det_reset <= 1'b0;
            r_det_x     <= 1'b0;
            r_det_m     <= 1'b0;
`ifdef SEQ_CTRL_FIRST_HIT_EN
            r_first_hit   <= '0;
            r_first_valid <= 1'b0;
`endif
        end else begin
            r_done      <= 1'b0;
            r_det_reset <= 1'b0;
            r_det_x     <= 1'b0;

            if (w_hit) begin
                if (r_hit_count != c_cnt_max) begin
                    r_hit_count <= r_hit_count + CW'(1);
                end
`ifdef SEQ_CTRL_FIRST_HIT_EN
                if (!r_first_valid) begin
                    r_first_hit   <= CW'(w_sample_idx);
                    r_first_valid <= 1'b1;
                end
`endif
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shift     <= pattern;
                        r_det_m     <= mode;
                        r_hit_count <= '0;
                        r_idx       <= '0;
                        r_det_reset <= 1'b1;
`ifdef SEQ_CTRL_FIRST_HIT_EN
                        r_first_hit   <= '0;
                        r_first_valid <= 1'b0;
`endif
                        r_state     <= S_RST;
                    end
                end
                S_RST: begin
                    r_det_x <= r_shift[N-1];
                    r_shift <= {r_shift[N-2:0], 1'b0};
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (r_idx == c_last_idx) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_idx   <= r_idx + IW'(1);
                        r_det_x <= r_shift[N-1];
                        r_shift <= {r_shift[N-2:0], 1'b0};
                    end
                end
                S_DRAIN: begin
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign hit_count = r_hit_count;
    assign det_reset = r_det_reset;
    assign det_x     = r_det_x;
    assign det_m     = r_det_m;
`ifdef SEQ_CTRL_FIRST_HIT_EN
    assign first_hit   = r_first_hit;
    assign first_valid = r_first_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_seq_detect_ctrl                                         |
// | Description : Self-checking bench for seq_detect_ctrl with a run-phase   |
// |               reference model and selectable detector stubs.             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_seq_detect_ctrl;

    localparam int N   = 44;
    localparam int CW  = 6;
    localparam int CW2 = 4;
    localparam logic [N-1:0] c_pat = 44'b01100010101101011011111001011011011011101010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset   = 1'b1;
    logic          start   = 1'b0;
    logic          mode    = 1'b0;
    logic [N-1:0]  pattern = '0;
    logic          busy, done, det_reset, det_x, det_m, det_z;
    logic [CW-1:0] hit_count;
`ifdef SEQ_CTRL_FIRST_HIT_EN
    logic [CW-1:0] first_hit;
    logic          first_valid;
`endif

    // Detector stubs: 0 = Mealy echo, 1 = Moore echo (registered), 2 = random Z
    int   zmode  = 0;
    logic z_rand = 1'b0;
    logic z_reg  = 1'b0;
    always @(posedge clk) z_reg <= det_x;
    assign det_z = (zmode == 0) ? det_x : (zmode == 1) ? z_reg : z_rand;

    seq_detect_ctrl #(.N(N), .CW(CW)) u_dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .pattern(pattern),
        .busy(busy), .done(done), .hit_count(hit_count), .det_reset(det_reset),
        .det_x(det_x), .det_m(det_m),
`ifdef SEQ_CTRL_FIRST_HIT_EN
        .first_hit(first_hit), .first_valid(first_valid),
`endif
        .det_z(det_z)
    );

    // Narrow-counter instance for saturation
    logic           start2 = 1'b0;
    logic [N-1:0]   pattern2 = '1;
    logic           busy2, done2, det_reset2, det_x2, det_m2, det_z2;
    logic [CW2-1:0] hit2;
`ifdef SEQ_CTRL_FIRST_HIT_EN
    logic [CW2-1:0] first_hit2;
    logic           first_valid2;
`endif
    assign det_z2 = det_x2;

    seq_detect_ctrl #(.N(N), .CW(CW2)) u_dut_sat (
        .clk(clk), .reset(reset), .start(start2), .mode(1'b0), .pattern(pattern2),
        .busy(busy2), .done(done2), .hit_count(hit2), .det_reset(det_reset2),
        .det_x(det_x2), .det_m(det_m2),
`ifdef SEQ_CTRL_FIRST_HIT_EN
        .first_hit(first_hit2), .first_valid(first_valid2),
`endif
        .det_z(det_z2)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_p is the cycle number since the accepted start
    // (0 = idle, 1 = detector reset, 2..N+1 = pattern bits, N+3 = done).
    int           m_p      = 0;
    logic [N-1:0] m_pat    = '0;
    logic         m_mode   = 1'b0;
    int           m_cnt    = 0;
    int           m_first  = 0;
    logic         m_fv     = 1'b0;
    logic         m_prev_x = 1'b0;
    logic         m_cur_x;
    logic         m_z;
    int           m_k;

    function automatic logic exp_x(input int p);
        if (p >= 2 && p <= N + 1) return m_pat[N-1-(p-2)];
        return 1'b0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_p = 0; m_mode = 1'b0; m_cnt = 0; m_first = 0; m_fv = 1'b0; m_prev_x = 1'b0;
        end else begin
            m_cur_x = exp_x(m_p);
            m_z = (zmode == 0) ? m_cur_x : (zmode == 1) ? m_prev_x : z_rand;
            m_k = -1;
            if (!m_mode && m_p >= 2 && m_p <= N + 1) m_k = m_p - 2;
            if (m_mode && m_p >= 3 && m_p <= N + 2) m_k = m_p - 3;
            if (m_k >= 0 && m_z) begin
                if (m_cnt < (2 ** CW) - 1) m_cnt++;
                if (!m_fv) begin m_fv = 1'b1; m_first = m_k; end
            end
            m_prev_x = m_cur_x;
            if (m_p == 0) begin
                if (start) begin
                    m_p = 1; m_pat = pattern; m_mode = mode;
                    m_cnt = 0; m_first = 0; m_fv = 1'b0;
                end
            end else begin
                m_p = (m_p == N + 3) ? 0 : m_p + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", busy, m_p != 0);
        check("done", done, m_p == N + 3);
        check("det_reset", det_reset, m_p == 1);
        check("det_x", det_x, exp_x(m_p));
        check("det_m", det_m, m_mode);
        check("hit_count", hit_count, m_cnt);
`ifdef SEQ_CTRL_FIRST_HIT_EN
        check("first_hit", first_hit, m_first);
        check("first_valid", first_valid, m_fv);
`endif
    end

    // Called at posedge+1 in an idle cycle; returns at posedge+1 of the first idle cycle after.
    task automatic run_one(input logic [N-1:0] p, input logic md, input int zm, input bit noisy,
                           output int lat, output int ndone, output logic [N-1:0] xs);
        zmode = zm; pattern = p; mode = md; start = 1'b1; z_rand = 1'($urandom);
        lat = -1; ndone = 0; xs = '0;
        for (int c = 1; c <= N + 8; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (zm == 2) z_rand = 1'($urandom);
            if (c >= 2 && c <= N + 1) xs[N-1-(c-2)] = det_x;
            if (done) begin ndone++; if (lat < 0) lat = c; end
            if (!busy) break;
            if (noisy) begin
                start = 1'($urandom); mode = 1'($urandom); pattern = N'({$urandom, $urandom});
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int lat, nd, lat2;
        logic [N-1:0] xs, p;
        logic md;

        #2 reset = 1'b0;
        #1;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst hit_count", hit_count, 0);
        check("rst det_reset", det_reset, 0);
        check("rst det_x", det_x, 0);
        check("rst det_m", det_m, 0);
`ifdef SEQ_CTRL_FIRST_HIT_EN
        check("rst first_hit", first_hit, 0);
        check("rst first_valid", first_valid, 0);
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Mealy echo with the reference pattern
        run_one(c_pat, 1'b0, 0, 1'b0, lat, nd, xs);
        check("mealy done latency", lat, 47);
        check("mealy done pulses", nd, 1);
        check("mealy hit_count", hit_count, 26);
        check("mealy det_x stream", xs, c_pat);
        repeat (3) @(posedge clk);
        #1 check("hit_count held", hit_count, 26);

        // Moore echo, last bit sampled in DRAIN
        run_one(c_pat, 1'b1, 1, 1'b0, lat, nd, xs);
        check("moore hit_count", hit_count, 26);
        check("moore det_m", det_m, 1);
        run_one(44'h0000_0000_001, 1'b1, 1, 1'b0, lat, nd, xs);
        check("moore drain sample", hit_count, 1);

        // Start and mode disturbed during the run
        p = N'({$urandom, $urandom});
        run_one(p, 1'b0, 0, 1'b1, lat, nd, xs);
        check("noisy done pulses", nd, 1);
        check("noisy done latency", lat, N + 3);
        check("noisy det_m", det_m, 0);
        check("noisy hit_count", hit_count, $countones(p));

        // Reset in RUN cycle 10
        zmode = 0; pattern = c_pat; mode = 1'b0; start = 1'b1;
        repeat (12) begin @(posedge clk); #1; start = 1'b0; end
        #2 reset = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort det_x", det_x, 0);
        check("abort hit_count", hit_count, 0);
        check("abort det_m", det_m, 0);
        nd = 0;
        for (int c = 0; c < N + 6; c++) begin
            @(posedge clk); #1;
            if (c == 2) reset = 1'b1;
            if (done) nd++;
        end
        check("abort no done", nd, 0);
        run_one(c_pat, 1'b0, 0, 1'b0, lat, nd, xs);
        check("restart hit_count", hit_count, 26);

`ifdef SEQ_CTRL_FIRST_HIT_EN
        p = {3'b001, 41'(N'({$urandom, $urandom}))};
        run_one(p, 1'b0, 0, 1'b0, lat, nd, xs);
        check("first_hit index", first_hit, 2);
        check("first_valid set", first_valid, 1);
        run_one('0, 1'b0, 0, 1'b0, lat, nd, xs);
        check("first_valid cleared", first_valid, 0);
        check("first_hit cleared", first_hit, 0);
`endif

        // Randomised runs against the model
        for (int r = 0; r < 24; r++) begin
            p  = N'({$urandom, $urandom});
            md = 1'($urandom);
            run_one(p, md, int'($urandom_range(0, 2)), 1'($urandom), lat, nd, xs);
            check("rand done latency", lat, N + 3);
            repeat ($urandom_range(0, 3)) begin
                mode = 1'($urandom); pattern = N'({$urandom, $urandom});
                @(posedge clk); #1;
            end
        end

        // Saturation on the narrow counter
        start2 = 1'b1; lat2 = -1;
        for (int c = 1; c <= N + 8; c++) begin
            @(posedge clk); #1;
            start2 = 1'b0;
            if (c == 1) check("sat det_reset", det_reset2, 1);
            if (done2 && lat2 < 0) lat2 = c;
            if (!busy2) break;
        end
        check("sat done latency", lat2, N + 3);
        check("sat hit_count", hit2, 15);
        check("sat det_m", det_m2, 0);
`ifdef SEQ_CTRL_FIRST_HIT_EN
        check("sat first_valid", first_valid2, 1);
        check("sat first_hit", first_hit2, 0);
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
